// File: rtl/bus_arbiter.sv
// -----------------------------------------------------------------------------
// bus_arbiter
//
// Two-master, one-slave arbiter for the single-issue CPU/memory bus. Each
// master gets a one-deep pending buffer. Buffered requests are serialised onto
// the slave with round-robin fairness. Each response is routed back to the
// master that issued the access. A response timeout stops a silent slave from
// hanging either master.
//
// Parameters
//   TIMEOUT_CYCLES : cycles to wait for i_s_DV after issue before aborting
//   CNT_W          : timeout counter width, 2**CNT_W > TIMEOUT_CYCLES
//   ERR_DATA       : data returned to the master on a timed-out access
//
// Ports
//   i_clk, i_rst_n          : clock, synchronous active-low reset
//   i_mX_data/address       : master X write data and address (X = 0, 1)
//   i_mX_bhw                : master X byte/half/word code, passed through
//   i_mX_write_notread      : master X direction, 1 = write
//   i_mX_DV                 : master X request strobe (one-cycle pulse)
//   o_mX_data/DV/err        : master X response data, strobe, timeout flag
//   o_s_data/address/bhw    : slave request fields, held between issues
//   o_s_write_notread       : slave direction
//   o_s_DV                  : slave request strobe (one-cycle pulse)
//   i_s_data, i_s_DV        : slave response data and strobe
//   o_grant                 : one-hot owner of the access in flight, 00 idle
//   o_busy                  : high while an access is issued or outstanding
// -----------------------------------------------------------------------------
module bus_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned CNT_W          = 11,
  parameter logic [31:0] ERR_DATA       = 32'hDEADBEEF
) (
  input  logic        i_clk,
  input  logic        i_rst_n,

  input  logic [31:0] i_m0_data,
  input  logic [31:0] i_m0_address,
  input  logic [2:0]  i_m0_bhw,
  input  logic        i_m0_write_notread,
  input  logic        i_m0_DV,
  output logic [31:0] o_m0_data,
  output logic        o_m0_DV,
  output logic        o_m0_err,

  input  logic [31:0] i_m1_data,
  input  logic [31:0] i_m1_address,
  input  logic [2:0]  i_m1_bhw,
  input  logic        i_m1_write_notread,
  input  logic        i_m1_DV,
  output logic [31:0] o_m1_data,
  output logic        o_m1_DV,
  output logic        o_m1_err,

  output logic [31:0] o_s_data,
  output logic [31:0] o_s_address,
  output logic [2:0]  o_s_bhw,
  output logic        o_s_write_notread,
  output logic        o_s_DV,
  input  logic [31:0] i_s_data,
  input  logic        i_s_DV,

  output logic [1:0]  o_grant,
  output logic        o_busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_e;

  typedef struct packed {
    logic [31:0] data;
    logic [31:0] addr;
    logic [2:0]  bhw;
    logic        wnr;
  } req_t;

  state_e           state_q, state_d;
  logic [1:0]       pendValid_q, pendValid_d;
  req_t             pendReq_q [2];
  req_t             pendReq_d [2];
  req_t             sReq_q, sReq_d;
  logic             grant_q, grant_d;
  logic             lastServed_q, lastServed_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      rspData_q [2];
  logic [31:0]      rspData_d [2];
  logic [1:0]       rspDv_q, rspDv_d;
  logic [1:0]       rspErr_q, rspErr_d;

  req_t             reqIn0, reqIn1;
  logic             pick;
  logic             canGrant;
  logic             rspCycle;
  logic             timeoutHit;

  assign reqIn0 = {i_m0_data, i_m0_address, i_m0_bhw, i_m0_write_notread};
  assign reqIn1 = {i_m1_data, i_m1_address, i_m1_bhw, i_m1_write_notread};

  // Arbitration. No grant is made in the cycle a response is presented. That
  // keeps the next slave request at least two cycles after the response, and
  // it lets the master that was just answered re-request in time to compete.
  always_comb begin
    rspCycle   = |rspDv_q;
    canGrant   = (state_q == IDLE) && (|pendValid_q) && !rspCycle;
    pick       = (&pendValid_q) ? ~lastServed_q : pendValid_q[1];
    timeoutHit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
  end

  // Next-state logic. Buffer capture, the FSM and response generation are
  // handled here.
  always_comb begin
    state_d      = state_q;
    pendValid_d  = pendValid_q;
    pendReq_d    = pendReq_q;
    sReq_d       = sReq_q;
    grant_d      = grant_q;
    lastServed_d = lastServed_q;
    cnt_d        = cnt_q;
    rspData_d    = rspData_q;
    rspDv_d      = 2'b00;
    rspErr_d     = 2'b00;

    // A request arriving while the buffer is still occupied is dropped.
    if (i_m0_DV && !pendValid_q[0]) begin
      pendValid_d[0] = 1'b1;
      pendReq_d[0]   = reqIn0;
    end
    if (i_m1_DV && !pendValid_q[1]) begin
      pendValid_d[1] = 1'b1;
      pendReq_d[1]   = reqIn1;
    end

    case (state_q)
      IDLE: begin
        if (canGrant) begin
          grant_d = pick;
          sReq_d  = pendReq_q[pick];
          state_d = ISSUE;
        end
      end

      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT;
      end

      WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (i_s_DV) begin
          rspData_d[grant_q]   = i_s_data;
          rspDv_d[grant_q]     = 1'b1;
          pendValid_d[grant_q] = 1'b0;
          lastServed_d         = grant_q;
          state_d              = IDLE;
        end else if (timeoutHit) begin
          // A timed-out access leaves the round-robin record unchanged.
          rspData_d[grant_q]   = ERR_DATA;
          rspDv_d[grant_q]     = 1'b1;
          rspErr_d[grant_q]    = 1'b1;
          pendValid_d[grant_q] = 1'b0;
          state_d              = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // All state registers. Reset also sets the round-robin record to master 1,
  // so master 0 wins the first tie.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q      <= IDLE;
      pendValid_q  <= 2'b00;
      pendReq_q[0] <= '0;
      pendReq_q[1] <= '0;
      sReq_q       <= '0;
      grant_q      <= 1'b0;
      lastServed_q <= 1'b1;
      cnt_q        <= '0;
      rspData_q[0] <= '0;
      rspData_q[1] <= '0;
      rspDv_q      <= 2'b00;
      rspErr_q     <= 2'b00;
    end else begin
      state_q      <= state_d;
      pendValid_q  <= pendValid_d;
      pendReq_q[0] <= pendReq_d[0];
      pendReq_q[1] <= pendReq_d[1];
      sReq_q       <= sReq_d;
      grant_q      <= grant_d;
      lastServed_q <= lastServed_d;
      cnt_q        <= cnt_d;
      rspData_q[0] <= rspData_d[0];
      rspData_q[1] <= rspData_d[1];
      rspDv_q      <= rspDv_d;
      rspErr_q     <= rspErr_d;
    end
  end

  // o_grant is visible from the decision cycle onward. It stays up through the
  // cycle in which the owner's response is presented.
  always_comb begin
    o_grant = 2'b00;
    if (state_q != IDLE || rspCycle) begin
      o_grant = {grant_q, ~grant_q};
    end else if (canGrant) begin
      o_grant = {pick, ~pick};
    end
  end

  assign o_m0_data         = rspData_q[0];
  assign o_m0_DV           = rspDv_q[0];
  assign o_m0_err          = rspErr_q[0];
  assign o_m1_data         = rspData_q[1];
  assign o_m1_DV           = rspDv_q[1];
  assign o_m1_err          = rspErr_q[1];

  assign o_s_data          = sReq_q.data;
  assign o_s_address       = sReq_q.addr;
  assign o_s_bhw           = sReq_q.bhw;
  assign o_s_write_notread = sReq_q.wnr;
  assign o_s_DV            = (state_q == ISSUE);
  assign o_busy            = (state_q == ISSUE) || (state_q == WAIT);

endmodule

// File: tb/tb_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bus_arbiter
//
// Directed testbench for bus_arbiter, built with TIMEOUT_CYCLES = 8. A
// transaction-level reference model predicts every output on every cycle.
// Directed scenarios add hand-computed literal checks.
// -----------------------------------------------------------------------------
module tb_bus_arbiter;

  localparam int unsigned TO      = 8;
  localparam logic [31:0] ERRDATA = 32'hDEADBEEF;

  typedef struct packed {
    logic [31:0] data;
    logic [31:0] addr;
    logic [2:0]  bhw;
    logic        wnr;
  } req_t;

  logic        i_clk;
  logic        i_rst_n;
  logic [31:0] i_m0_data, i_m0_address;
  logic [2:0]  i_m0_bhw;
  logic        i_m0_write_notread, i_m0_DV;
  logic [31:0] o_m0_data;
  logic        o_m0_DV, o_m0_err;
  logic [31:0] i_m1_data, i_m1_address;
  logic [2:0]  i_m1_bhw;
  logic        i_m1_write_notread, i_m1_DV;
  logic [31:0] o_m1_data;
  logic        o_m1_DV, o_m1_err;
  logic [31:0] o_s_data, o_s_address;
  logic [2:0]  o_s_bhw;
  logic        o_s_write_notread, o_s_DV;
  logic [31:0] i_s_data;
  logic        i_s_DV;
  logic [1:0]  o_grant;
  logic        o_busy;

  bus_arbiter #(
    .TIMEOUT_CYCLES(TO),
    .CNT_W(4),
    .ERR_DATA(ERRDATA)
  ) dut (
    .i_clk(i_clk),
    .i_rst_n(i_rst_n),
    .i_m0_data(i_m0_data),
    .i_m0_address(i_m0_address),
    .i_m0_bhw(i_m0_bhw),
    .i_m0_write_notread(i_m0_write_notread),
    .i_m0_DV(i_m0_DV),
    .o_m0_data(o_m0_data),
    .o_m0_DV(o_m0_DV),
    .o_m0_err(o_m0_err),
    .i_m1_data(i_m1_data),
    .i_m1_address(i_m1_address),
    .i_m1_bhw(i_m1_bhw),
    .i_m1_write_notread(i_m1_write_notread),
    .i_m1_DV(i_m1_DV),
    .o_m1_data(o_m1_data),
    .o_m1_DV(o_m1_DV),
    .o_m1_err(o_m1_err),
    .o_s_data(o_s_data),
    .o_s_address(o_s_address),
    .o_s_bhw(o_s_bhw),
    .o_s_write_notread(o_s_write_notread),
    .o_s_DV(o_s_DV),
    .i_s_data(i_s_data),
    .i_s_DV(i_s_DV),
    .o_grant(o_grant),
    .o_busy(o_busy)
  );

  int testsRun  = 0;
  int failCount = 0;
  int cyc       = 0;
  int sDvCount  = 0;
  int m0DvCount = 0;

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, actual, expected);
    end
  endtask

  // Reference model. It tracks pending requests and the access in flight as
  // timestamps: issue cycle, response cycle, and the timeout deadline.
  bit         live;
  logic [1:0] mPend;
  req_t       pendReq [2];
  bit         mActive;
  bit         owner;
  bit         lastServed;
  int         issueAt;
  int         respAt;
  bit         respOwner;
  bit         respErr;
  logic [31:0] holdData [2];
  req_t       sHold;
  logic [1:0] oldPend;
  logic [1:0] expGrant;
  bit         isResp;

  function automatic logic [1:0] onehot(input bit m);
    if (m) return 2'b10;
    return 2'b01;
  endfunction

  function automatic bit choose(input logic [1:0] p, input bit last);
    if (p == 2'b11) begin
      if (last) return 1'b0;
      return 1'b1;
    end
    if (p == 2'b10) return 1'b1;
    return 1'b0;
  endfunction

  task automatic modelRespond(input logic [31:0] d, input bit err);
    respAt          = cyc + 1;
    respOwner       = owner;
    respErr         = err;
    holdData[owner] = d;
    mPend[owner]    = 1'b0;
    mActive         = 1'b0;
    if (!err) lastServed = owner;
  endtask

  always @(negedge i_clk) begin
    isResp = (cyc == respAt);
    if (live) begin
      expGrant = 2'b00;
      if (mActive)      expGrant = onehot(owner);
      else if (isResp)  expGrant = onehot(respOwner);
      else if (|mPend)  expGrant = onehot(choose(mPend, lastServed));
      checkOutput("grant",   32'(o_grant), 32'(expGrant));
      checkOutput("busy",    32'(o_busy), 32'(mActive));
      checkOutput("s_DV",    32'(o_s_DV), 32'(mActive && cyc == issueAt));
      checkOutput("s_data",  o_s_data, sHold.data);
      checkOutput("s_addr",  o_s_address, sHold.addr);
      checkOutput("s_bhw",   32'(o_s_bhw), 32'(sHold.bhw));
      checkOutput("s_wnr",   32'(o_s_write_notread), 32'(sHold.wnr));
      checkOutput("m0_DV",   32'(o_m0_DV), 32'(isResp && !respOwner));
      checkOutput("m0_err",  32'(o_m0_err), 32'(isResp && !respOwner && respErr));
      checkOutput("m0_data", o_m0_data, holdData[0]);
      checkOutput("m1_DV",   32'(o_m1_DV), 32'(isResp && respOwner));
      checkOutput("m1_err",  32'(o_m1_err), 32'(isResp && respOwner && respErr));
      checkOutput("m1_data", o_m1_data, holdData[1]);
      if (o_s_DV)  sDvCount++;
      if (o_m0_DV) m0DvCount++;
    end

    if (!i_rst_n) begin
      live        = 1'b1;
      mPend       = 2'b00;
      mActive     = 1'b0;
      owner       = 1'b0;
      lastServed  = 1'b1;
      issueAt     = -10;
      respAt      = -1;
      respOwner   = 1'b0;
      respErr     = 1'b0;
      holdData[0] = '0;
      holdData[1] = '0;
      sHold       = '0;
    end else if (live) begin
      oldPend = mPend;
      if (mActive) begin
        if (cyc > issueAt && i_s_DV)          modelRespond(i_s_data, 1'b0);
        else if (cyc - issueAt == int'(TO))   modelRespond(ERRDATA, 1'b1);
      end else if (!isResp && |oldPend) begin
        owner   = choose(oldPend, lastServed);
        mActive = 1'b1;
        issueAt = cyc + 1;
        sHold   = pendReq[owner];
      end
      if (i_m0_DV && !oldPend[0]) begin
        mPend[0]   = 1'b1;
        pendReq[0] = {i_m0_data, i_m0_address, i_m0_bhw, i_m0_write_notread};
      end
      if (i_m1_DV && !oldPend[1]) begin
        mPend[1]   = 1'b1;
        pendReq[1] = {i_m1_data, i_m1_address, i_m1_bhw, i_m1_write_notread};
      end
    end
  end

  // Stimulus helpers. Inputs change 1 ns after the rising edge. Pulses last
  // exactly one cycle.
  task automatic step();
    @(posedge i_clk);
    #1;
    i_m0_DV = 1'b0;
    i_m1_DV = 1'b0;
    i_s_DV  = 1'b0;
  endtask

  task automatic applyStimulus(input int m, input logic [31:0] data,
                               input logic [31:0] addr, input logic [2:0] bhw,
                               input logic wnr);
    if (m == 0) begin
      i_m0_data = data; i_m0_address = addr; i_m0_bhw = bhw;
      i_m0_write_notread = wnr; i_m0_DV = 1'b1;
    end else begin
      i_m1_data = data; i_m1_address = addr; i_m1_bhw = bhw;
      i_m1_write_notread = wnr; i_m1_DV = 1'b1;
    end
  endtask

  task automatic waitIssue();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (o_s_DV) begin
        seen = 1'b1;
        break;
      end
      step();
    end
    if (!seen) checkOutput("issue_wait", 32'(o_s_DV), 32'd1);
  endtask

  task automatic respond(input int delay, input logic [31:0] d);
    repeat (delay) step();
    i_s_DV   = 1'b1;
    i_s_data = d;
    step();
  endtask

  task automatic doReset();
    i_rst_n = 1'b0;
    step();
    step();
    i_rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int t0;
    i_rst_n = 1'b0;
    i_m0_data = '0; i_m0_address = '0; i_m0_bhw = '0; i_m0_write_notread = 1'b0; i_m0_DV = 1'b0;
    i_m1_data = '0; i_m1_address = '0; i_m1_bhw = '0; i_m1_write_notread = 1'b0; i_m1_DV = 1'b0;
    i_s_data = '0; i_s_DV = 1'b0;
    repeat (3) step();
    i_rst_n = 1'b1;
    checkOutput("rst_grant", 32'(o_grant), 32'd0);
    checkOutput("rst_busy",  32'(o_busy), 32'd0);
    checkOutput("rst_s_DV",  32'(o_s_DV), 32'd0);

    // Single m0 read. The slave answers 3 cycles after o_s_DV.
    applyStimulus(0, 32'h0, 32'h100, 3'b010, 1'b0);
    step();
    checkOutput("s1_grant_decision", 32'(o_grant), 32'd1);
    checkOutput("s1_no_early_issue", 32'(o_s_DV), 32'd0);
    step();
    checkOutput("s1_issue",   32'(o_s_DV), 32'd1);
    checkOutput("s1_addr",    o_s_address, 32'h100);
    checkOutput("s1_busy",    32'(o_busy), 32'd1);
    respond(3, 32'h12345678);
    checkOutput("s1_m0_DV",   32'(o_m0_DV), 32'd1);
    checkOutput("s1_m0_data", o_m0_data, 32'h12345678);
    checkOutput("s1_m0_err",  32'(o_m0_err), 32'd0);
    checkOutput("s1_m1_DV",   32'(o_m1_DV), 32'd0);
    step();
    checkOutput("s1_pulse_width", 32'(o_m0_DV), 32'd0);
    checkOutput("s1_idle_grant",  32'(o_grant), 32'd0);

    // Tie right after reset: m0 wins, then m1, with a 2-cycle gap.
    doReset();
    applyStimulus(0, 32'h0, 32'h200, 3'b010, 1'b0);
    applyStimulus(1, 32'h0, 32'h300, 3'b010, 1'b0);
    step();
    checkOutput("tieA_grant", 32'(o_grant), 32'd1);
    waitIssue();
    checkOutput("tieA_first", o_s_address, 32'h200);
    respond(1, 32'hA0A0A0A0);
    checkOutput("tieA_m0_DV", 32'(o_m0_DV), 32'd1);
    step();
    step();
    checkOutput("tieA_gap_issue", 32'(o_s_DV), 32'd1);
    checkOutput("tieA_second",    o_s_address, 32'h300);
    checkOutput("tieA_grant2",    32'(o_grant), 32'd2);
    respond(1, 32'hB0B0B0B0);
    checkOutput("tieA_m1_data", o_m1_data, 32'hB0B0B0B0);

    // Serve m0 alone so that m0 is the last served. The next tie goes to m1.
    step();
    applyStimulus(0, 32'h0, 32'h350, 3'b010, 1'b0);
    step();
    waitIssue();
    respond(1, 32'h35353535);
    step();
    applyStimulus(0, 32'h0, 32'h400, 3'b010, 1'b0);
    applyStimulus(1, 32'h0, 32'h500, 3'b010, 1'b0);
    step();
    checkOutput("tieB_grant", 32'(o_grant), 32'd2);
    waitIssue();
    checkOutput("tieB_first", o_s_address, 32'h500);
    respond(2, 32'h55555555);
    checkOutput("tieB_m1_DV", 32'(o_m1_DV), 32'd1);
    waitIssue();
    checkOutput("tieB_second", o_s_address, 32'h400);
    respond(2, 32'h44444444);
    checkOutput("tieB_m0_data", o_m0_data, 32'h44444444);

    // m1 write. The fields are presented on the slave at o_s_DV.
    step();
    applyStimulus(1, 32'hCAFEF00D, 32'h600, 3'b010, 1'b1);
    step();
    waitIssue();
    checkOutput("wr_data", o_s_data, 32'hCAFEF00D);
    checkOutput("wr_bhw",  32'(o_s_bhw), 32'd2);
    checkOutput("wr_wnr",  32'(o_s_write_notread), 32'd1);
    respond(2, 32'h0);
    checkOutput("wr_m1_DV",  32'(o_m1_DV), 32'd1);
    checkOutput("wr_m1_err", 32'(o_m1_err), 32'd0);

    // Silent slave. The error response comes TO+1 cycles after o_s_DV.
    step();
    applyStimulus(0, 32'h0, 32'h700, 3'b010, 1'b0);
    step();
    waitIssue();
    t0 = cyc;
    for (int i = 0; i < 40; i++) begin
      step();
      if (o_m0_DV) break;
    end
    checkOutput("to_latency", 32'(cyc - t0), 32'd9);
    checkOutput("to_data",    o_m0_data, 32'hDEADBEEF);
    checkOutput("to_err",     32'(o_m0_err), 32'd1);
    step();
    checkOutput("to_err_width", 32'(o_m0_err), 32'd0);
    applyStimulus(1, 32'h0, 32'h800, 3'b010, 1'b0);
    step();
    waitIssue();
    checkOutput("to_next_addr", o_s_address, 32'h800);
    respond(1, 32'h5555AAAA);
    checkOutput("to_next_m1_DV",  32'(o_m1_DV), 32'd1);
    checkOutput("to_next_m1_err", 32'(o_m1_err), 32'd0);

    // Repeated m0 pulses while m0 is pending are dropped.
    step();
    t0 = sDvCount;
    begin
      int r0;
      r0 = m0DvCount;
      applyStimulus(0, 32'h0, 32'h900, 3'b010, 1'b0);
      step();
      applyStimulus(0, 32'h0, 32'hA00, 3'b010, 1'b0);
      step();
      waitIssue();
      checkOutput("dup_addr", o_s_address, 32'h900);
      step();
      applyStimulus(0, 32'h0, 32'hB00, 3'b010, 1'b0);
      respond(2, 32'h00000099);
      repeat (8) step();
      checkOutput("dup_issues",    32'(sDvCount - t0), 32'd1);
      checkOutput("dup_responses", 32'(m0DvCount - r0), 32'd1);
    end

    // Reset while the slave is outstanding. A late answer must be discarded.
    applyStimulus(0, 32'h0, 32'hC00, 3'b010, 1'b0);
    step();
    waitIssue();
    step();
    i_rst_n = 1'b0;
    step();
    checkOutput("mrst_busy",    32'(o_busy), 32'd0);
    checkOutput("mrst_grant",   32'(o_grant), 32'd0);
    checkOutput("mrst_m0_data", o_m0_data, 32'd0);
    checkOutput("mrst_s_addr",  o_s_address, 32'd0);
    i_rst_n  = 1'b1;
    i_s_DV   = 1'b1;
    i_s_data = 32'h77777777;
    step();
    checkOutput("mrst_no_m0_DV", 32'(o_m0_DV), 32'd0);
    checkOutput("mrst_no_m1_DV", 32'(o_m1_DV), 32'd0);
    applyStimulus(1, 32'h0, 32'hD00, 3'b010, 1'b0);
    step();
    waitIssue();
    checkOutput("mrst_next_addr", o_s_address, 32'hD00);
    respond(1, 32'h13579BDF);
    checkOutput("mrst_next_m1_data", o_m1_data, 32'h13579BDF);

    repeat (3) step();
    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Two-master, one-slave arbiter for the single-issue CPU/memory bus. Master 0 is CPU_top's bus port. Master 1 is a secondary requester, such as a DMA or debug loader. The slave is memory_top's bus port. The arbiter buffers one request per master, serialises them onto the slave with round-robin fairness, returns each response to the master that issued it, and enforces a response timeout so a silent slave cannot hang either master.

## Interface
Parameters:
- TIMEOUT_CYCLES, 1024: cycles to wait for i_s_DV after issue before the arbiter aborts.
- CNT_W, 11: timeout counter width; must satisfy 2^CNT_W > TIMEOUT_CYCLES.
- ERR_DATA, 32'hDEADBEEF: data returned on a timed-out access.

Ports:
- i_clk  in  1  clock. All logic is on the rising edge.
- i_rst_n  in  1  reset. Synchronous and active-low.
- i_m0_data, i_m0_address  in  32 each  master 0 write data and address.
- i_m0_bhw  in  3  master 0 byte/half/word code, passed through unchanged.
- i_m0_write_notread  in  1  master 0 direction: 1 = write.
- i_m0_DV  in  1  master 0 request strobe, one-cycle pulse.
- o_m0_data  out  32  master 0 response data.
- o_m0_DV  out  1  master 0 response strobe, one-cycle pulse.
- o_m0_err  out  1  qualifies o_m0_DV: the access timed out.
- i_m1_*, o_m1_*  same set and widths as master 0, for master 1.
- o_s_data, o_s_address  out  32 each  slave write data and address.
- o_s_bhw  out  3  slave byte/half/word code.
- o_s_write_notread  out  1  slave direction.
- o_s_DV  out  1  slave request strobe, one-cycle pulse.
- i_s_data  in  32  slave response data.
- i_s_DV  in  1  slave response strobe. The slave pulses it once for every read and every write.
- o_grant  out  2  one-hot owner of the access in flight; 00 when idle.
- o_busy  out  1  1 in ISSUE and WAIT.

## Operation
- Per-master pending buffer: one valid bit plus latched data, address, bhw and write_notread.
  - An i_mX_DV pulse while the buffer is empty loads the buffer and sets valid.
  - An i_mX_DV pulse while valid is already set is dropped silently; masters must wait for their response.
- IDLE:
  - i_s_DV is ignored.
  - If any pending valid bit is set, grant one master and go to ISSUE.
  - If both are valid, grant the master not served last. After reset the last-served record holds master 1, so master 0 wins the first tie.
- ISSUE (one cycle):
  - o_s_DV = 1; the o_s_* fields carry the granted buffer.
  - Clear the timeout counter.
  - Go to WAIT.
- WAIT:
  - Counter increments each cycle.
  - On i_s_DV: register i_s_data into o_mX_data of the granted master, pulse o_mX_DV with o_mX_err = 0, clear that master's pending bit, record it as last served, go to IDLE.
  - If the counter reaches TIMEOUT_CYCLES without i_s_DV: o_mX_data = ERR_DATA, o_mX_DV = 1 and o_mX_err = 1 for the granted master, clear its pending bit, go to IDLE.
- A master's new i_mX_DV in the same cycle its o_mX_DV is high is accepted, because its pending bit clears on that edge.
- The o_s_* fields hold their last issued values outside ISSUE. Only o_s_DV qualifies them.
- Reset (any state, including mid-access):
  - State goes to IDLE; pending bits clear; last-served record set to master 1.
  - Every output is 0, including o_grant = 00 and o_busy = 0.
  - A slave response arriving after reset lands in IDLE and is discarded.

## Timing
- Request pulse in cycle N is captured at the end of N. The grant decision is made in N+1, and o_s_DV is high in N+2. Minimum request-to-slave latency is 2 cycles.
- Slave response i_s_DV in cycle K produces o_mX_DV in cycle K+1, registered.
- The arbiter is back in IDLE in K+1. The next o_s_DV is no earlier than K+3.
- Timeout: with o_s_DV in cycle T, the error response o_mX_DV is in cycle T+TIMEOUT_CYCLES+1.
- o_grant is set from the grant cycle and stays set through the o_mX_DV cycle.
- o_mX_DV and o_mX_err are exactly one cycle wide.
- i_s_DV in the ISSUE cycle is treated as a stray and ignored; a valid slave response comes no earlier than the cycle after o_s_DV.

## Test plan
- Single read by m0, address 0x100, slave answers 3 cycles after o_s_DV with 0x12345678 -> o_m0_DV one cycle later, o_m0_data = 0x12345678, o_m0_err = 0, o_m1_DV stays 0.
- Simultaneous m0 and m1 requests after reset -> m0 issued first, m1 issued next; then a second simultaneous pair -> m1 issued first, then m0.
- m1 write of 0xCAFEF00D, bhw = 3'b010 -> o_s_data, o_s_bhw and o_s_write_notread match at o_s_DV; slave ack returns o_m1_DV.
- TIMEOUT_CYCLES = 8 and a silent slave -> o_m0_DV with o_m0_data = 0xDEADBEEF and o_m0_err = 1 exactly 9 cycles after o_s_DV; a following m1 request is served normally.
- Second m0 pulse while m0 is pending -> exactly one slave access and one response.
- i_rst_n low during WAIT, then the slave answers -> no o_mX_DV, all outputs 0, and the next request is served normally.
